// File: rtl/rocc_pkg.sv
// Shared RoCC command/response types and custom-opcode constants.
package rocc_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPCODE_CUSTOM1 = 7'h2B;
    localparam logic [6:0] OPCODE_CUSTOM2 = 7'h5B;
    localparam logic [6:0] OPCODE_CUSTOM3 = 7'h7B;

    // Field order follows the R-type instruction encoding, MSB first.
    typedef struct packed {
        logic [6:0] funct;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rocc_resp_t;

endpackage

// File: rtl/rocc_resp_fifo.sv
// Response buffer between the accelerator io_resp port and the host.
// Full/empty come from read/write pointers carrying one extra wrap bit.
module rocc_resp_fifo
    import rocc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  rocc_resp_t din_i,
    input  logic       pop_i,
    output rocc_resp_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rocc_resp_t  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/rocc_cmd_issuer.sv
// Host-side RoCC initiator: registers host requests onto io_cmd, tracks
// outstanding xd=1 destinations in an rd scoreboard, buffers responses.
module rocc_cmd_issuer
    import rocc_pkg::*;
#(
    parameter logic [6:0] OPCODE          = OPCODE_CUSTOM0,
    parameter int         MAX_FUNCT       = 4,
    parameter int         MAX_OUTSTANDING = 8,
    parameter int         RSP_DEPTH       = 4,
    parameter int         TIMEOUT         = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [6:0]      req_funct,
    input  logic [4:0]      req_rd,
    input  logic            req_xd,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            io_cmd_valid,
    input  logic            io_cmd_ready,
    output logic [6:0]      io_cmd_bits_inst_funct,
    output logic [4:0]      io_cmd_bits_inst_rd,
    output logic            io_cmd_bits_inst_xd,
    output logic            io_cmd_bits_inst_xs1,
    output logic            io_cmd_bits_inst_xs2,
    output logic [4:0]      io_cmd_bits_inst_rs1,
    output logic [4:0]      io_cmd_bits_inst_rs2,
    output logic [6:0]      io_cmd_bits_inst_opcode,
    output logic [XLEN-1:0] io_cmd_bits_rs1,
    output logic [XLEN-1:0] io_cmd_bits_rs2,
    input  logic            io_resp_valid,
    output logic            io_resp_ready,
    input  logic [4:0]      io_resp_bits_rd,
    input  logic [XLEN-1:0] io_resp_bits_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy,
    output logic            err_bad_funct,
    output logic            err_unexpected,
    output logic            err_timeout
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic            cmd_valid_q, cmd_valid_d;
    logic [6:0]      funct_q, funct_d;
    logic [4:0]      rd_q, rd_d;
    logic            xd_q, xd_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [31:0]     pending_q, pending_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_bad_q, err_bad_d;
    logic            err_unexp_q, err_unexp_d;
    logic            err_tmo_q, err_tmo_d;

    logic slot_free, at_cap, req_fire, funct_ok, issue, set_pend;
    logic resp_fire, resp_hit, clr_pend, tmo_inc;
    logic fifo_full, fifo_empty;
    rocc_inst_t cmd_inst;
    rocc_resp_t fifo_din, fifo_dout;

    // Scoreboard checks use registered state only, so a same-cycle response
    // for req_rd does not unblock the request until the following cycle.
    assign slot_free = ~cmd_valid_q | io_cmd_ready;
    assign at_cap    = (outst_q == OW'(MAX_OUTSTANDING));
    assign req_ready = slot_free & ~(req_xd & (pending_q[req_rd] | at_cap));
    assign req_fire  = req_valid & req_ready;
    assign funct_ok  = (req_funct <= 7'(MAX_FUNCT));
    assign issue     = req_fire & funct_ok;
    assign set_pend  = issue & req_xd;
    assign resp_fire = io_resp_valid & io_resp_ready;
    assign resp_hit  = pending_q[io_resp_bits_rd];
    assign clr_pend  = resp_fire & resp_hit;
    assign tmo_inc   = (outst_q != '0) & ~resp_fire;

    always_comb begin
        cmd_valid_d = issue | (cmd_valid_q & ~io_cmd_ready);
        funct_d     = funct_q;
        rd_d        = rd_q;
        xd_d        = xd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        if (issue) begin
            funct_d = req_funct;
            rd_d    = req_rd;
            xd_d    = req_xd;
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
        end
        if (clr_pend) pending_d[io_resp_bits_rd] = 1'b0;
        if (set_pend) pending_d[req_rd] = 1'b1;
        outst_d = outst_q + OW'(set_pend) - OW'(clr_pend);
        if (!tmo_inc)                   tmo_d = '0;
        else if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
        err_bad_d   = err_bad_q | (req_fire & ~funct_ok);
        err_unexp_d = err_unexp_q | (resp_fire & ~resp_hit);
        err_tmo_d   = err_tmo_q | (tmo_inc & (tmo_q == TW'(TIMEOUT - 1)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_valid_q <= 1'b0;
            funct_q     <= '0;
            rd_q        <= '0;
            xd_q        <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pending_q   <= '0;
            outst_q     <= '0;
            tmo_q       <= '0;
            err_bad_q   <= 1'b0;
            err_unexp_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            funct_q     <= funct_d;
            rd_q        <= rd_d;
            xd_q        <= xd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            pending_q   <= pending_d;
            outst_q     <= outst_d;
            tmo_q       <= tmo_d;
            err_bad_q   <= err_bad_d;
            err_unexp_q <= err_unexp_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign cmd_inst = '{funct: funct_q, rs2: 5'd0, rs1: 5'd0, xd: xd_q,
                        xs1: 1'b1, xs2: 1'b1, rd: rd_q, opcode: OPCODE};

    assign io_cmd_valid            = cmd_valid_q;
    assign io_cmd_bits_inst_funct  = cmd_inst.funct;
    assign io_cmd_bits_inst_rd     = cmd_inst.rd;
    assign io_cmd_bits_inst_xd     = cmd_inst.xd;
    assign io_cmd_bits_inst_xs1    = cmd_inst.xs1;
    assign io_cmd_bits_inst_xs2    = cmd_inst.xs2;
    assign io_cmd_bits_inst_rs1    = cmd_inst.rs1;
    assign io_cmd_bits_inst_rs2    = cmd_inst.rs2;
    assign io_cmd_bits_inst_opcode = cmd_inst.opcode;
    assign io_cmd_bits_rs1         = rs1_q;
    assign io_cmd_bits_rs2         = rs2_q;

    assign fifo_din = '{rd: io_resp_bits_rd, data: io_resp_bits_data};

    rocc_resp_fifo #(.DEPTH(RSP_DEPTH)) u_resp_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (io_resp_valid),
        .din_i   (fifo_din),
        .pop_i   (rsp_ready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign io_resp_ready  = ~fifo_full;
    assign rsp_valid      = ~fifo_empty;
    assign rsp_rd         = fifo_dout.rd;
    assign rsp_data       = fifo_dout.data;
    assign busy           = (outst_q != '0) | cmd_valid_q | ~fifo_empty;
    assign err_bad_funct  = err_bad_q;
    assign err_unexpected = err_unexp_q;
    assign err_timeout    = err_tmo_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: table of single-command vectors plus
// hand sequences for back-pressure, hazards, limits, errors and async reset.
module tb_rocc_cmd_issuer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_xd;
    logic [6:0]  req_funct;
    logic [4:0]  req_rd;
    logic [63:0] req_rs1, req_rs2;
    logic        io_cmd_valid, io_cmd_ready;
    logic [6:0]  io_cmd_bits_inst_funct, io_cmd_bits_inst_opcode;
    logic [4:0]  io_cmd_bits_inst_rd, io_cmd_bits_inst_rs1, io_cmd_bits_inst_rs2;
    logic        io_cmd_bits_inst_xd, io_cmd_bits_inst_xs1, io_cmd_bits_inst_xs2;
    logic [63:0] io_cmd_bits_rs1, io_cmd_bits_rs2;
    logic        io_resp_valid, io_resp_ready;
    logic [4:0]  io_resp_bits_rd;
    logic [63:0] io_resp_bits_data;
    logic        rsp_valid, rsp_ready;
    logic [4:0]  rsp_rd;
    logic [63:0] rsp_data;
    logic        busy, err_bad_funct, err_unexpected, err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rocc_cmd_issuer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_rd(req_rd), .req_xd(req_xd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_bits_inst_funct(io_cmd_bits_inst_funct),
        .io_cmd_bits_inst_rd(io_cmd_bits_inst_rd),
        .io_cmd_bits_inst_xd(io_cmd_bits_inst_xd),
        .io_cmd_bits_inst_xs1(io_cmd_bits_inst_xs1),
        .io_cmd_bits_inst_xs2(io_cmd_bits_inst_xs2),
        .io_cmd_bits_inst_rs1(io_cmd_bits_inst_rs1),
        .io_cmd_bits_inst_rs2(io_cmd_bits_inst_rs2),
        .io_cmd_bits_inst_opcode(io_cmd_bits_inst_opcode),
        .io_cmd_bits_rs1(io_cmd_bits_rs1), .io_cmd_bits_rs2(io_cmd_bits_rs2),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .busy(busy), .err_bad_funct(err_bad_funct),
        .err_unexpected(err_unexpected), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [6:0]  funct;
        logic [4:0]  rd;
        logic        xd;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic        exp_issue;
        logic        exp_bad;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                            input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1; req_funct = f; req_rd = rd; req_xd = xd;
        req_rs1 = a; req_rs2 = b;
        #1;
        for (int i = 0; i < 64; i++) begin
            if (req_ready) break;
            step();
        end
        check("req_accept", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [4:0] rd, input logic [63:0] d);
        io_resp_valid = 1'b1; io_resp_bits_rd = rd; io_resp_bits_data = d;
        #1;
        for (int i = 0; i < 64; i++) begin
            if (io_resp_ready) break;
            step();
        end
        check("resp_accept", io_resp_ready, 1'b1);
        step();
        io_resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          funct  rd     xd    rs1                     rs2                     rdata              iss   bad
        vecs[0] = '{7'd1, 5'd5,  1'b1, 64'h10,                 64'h20,                 64'hABCD,          1'b1, 1'b0};
        vecs[1] = '{7'd0, 5'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 64'h0,             1'b1, 1'b0};
        vecs[2] = '{7'd4, 5'd31, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555,        1'b1, 1'b0};
        vecs[3] = '{7'd3, 5'd12, 1'b0, 64'h8000_0000_0000_0000, 64'h0,                 64'h0,             1'b1, 1'b0};
        vecs[4] = '{7'd5, 5'd9,  1'b1, 64'h99,                 64'h98,                 64'h0,             1'b0, 1'b1};
        vecs[5] = '{7'd6, 5'd2,  1'b0, 64'h66,                 64'h67,                 64'h0,             1'b0, 1'b1};
        vecs[6] = '{7'd2, 5'd7,  1'b1, 64'h70,                 64'h71,                 64'hDEAD_BEEF,     1'b1, 1'b1};

        reset = 1'b0;
        req_valid = 1'b0; req_funct = '0; req_rd = '0; req_xd = 1'b0;
        req_rs1 = '0; req_rs2 = '0;
        io_cmd_ready = 1'b1; io_resp_valid = 1'b0; io_resp_bits_rd = '0;
        io_resp_bits_data = '0; rsp_ready = 1'b0;
        #2;
        check("rst_cmd_valid", io_cmd_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_resp_ready", io_resp_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {err_bad_funct, err_unexpected, err_timeout}, 3'b000);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_cmd_rs1", io_cmd_bits_rs1, 64'h0);
        check("const_opcode", io_cmd_bits_inst_opcode, 7'h0B);
        check("const_xs", {io_cmd_bits_inst_xs1, io_cmd_bits_inst_xs2}, 2'b11);
        check("const_rsidx", {io_cmd_bits_inst_rs1, io_cmd_bits_inst_rs2}, 10'd0);
        #10 reset = 1'b1;
        step();

        // Table: one command each, response returned and popped when xd=1.
        for (int v = 0; v < 7; v++) begin
            send_req(vecs[v].funct, vecs[v].rd, vecs[v].xd, vecs[v].rs1, vecs[v].rs2);
            check("vec_cmd_valid", io_cmd_valid, vecs[v].exp_issue);
            check("vec_err_bad", err_bad_funct, vecs[v].exp_bad);
            if (vecs[v].exp_issue) begin
                check("vec_funct", io_cmd_bits_inst_funct, vecs[v].funct);
                check("vec_rd", io_cmd_bits_inst_rd, vecs[v].rd);
                check("vec_xd", io_cmd_bits_inst_xd, vecs[v].xd);
                check("vec_rs1", io_cmd_bits_rs1, vecs[v].rs1);
                check("vec_rs2", io_cmd_bits_rs2, vecs[v].rs2);
                check("vec_opcode", io_cmd_bits_inst_opcode, 7'h0B);
            end
            step();
            check("vec_cmd_drained", io_cmd_valid, 1'b0);
            check("vec_busy_pending", busy, vecs[v].exp_issue & vecs[v].xd);
            if (vecs[v].exp_issue && vecs[v].xd) begin
                send_resp(vecs[v].rd, vecs[v].rdata);
                check("vec_rsp_valid", rsp_valid, 1'b1);
                check("vec_rsp_rd", rsp_rd, vecs[v].rd);
                check("vec_rsp_data", rsp_data, vecs[v].rdata);
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
            end
            check("vec_busy_idle", busy, 1'b0);
        end
        check("vec_no_unexpected", err_unexpected, 1'b0);
        check("vec_no_timeout", err_timeout, 1'b0);

        // Back-pressure, then three back-to-back issues.
        io_cmd_ready = 1'b0;
        send_req(7'd1, 5'd1, 1'b0, 64'hA1, 64'hA2);
        req_valid = 1'b1; req_funct = 7'd2; req_rd = 5'd2; req_xd = 1'b0;
        req_rs1 = 64'hB1; req_rs2 = 64'hB2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_hold_valid", io_cmd_valid, 1'b1);
            check("bp_hold_rs1", io_cmd_bits_rs1, 64'hA1);
            check("bp_hold_funct", io_cmd_bits_inst_funct, 7'd1);
            step();
        end
        io_cmd_ready = 1'b1;
        #1;
        check("b2b_ready0", req_ready, 1'b1);
        step();
        check("b2b_cmd0", {io_cmd_valid, io_cmd_bits_inst_funct}, {1'b1, 7'd2});
        req_funct = 7'd3; req_rs1 = 64'hC1;
        #1;
        check("b2b_ready1", req_ready, 1'b1);
        step();
        check("b2b_cmd1", {io_cmd_valid, io_cmd_bits_inst_funct}, {1'b1, 7'd3});
        check("b2b_rs1_1", io_cmd_bits_rs1, 64'hC1);
        req_funct = 7'd4; req_rs1 = 64'hD1;
        step();
        check("b2b_cmd2", {io_cmd_valid, io_cmd_bits_inst_funct}, {1'b1, 7'd4});
        req_valid = 1'b0;
        step();
        check("b2b_drained", io_cmd_valid, 1'b0);

        // rd hazard: second rd=7 stalls, rd=8 passes, rd=7 issues after response.
        rsp_ready = 1'b1;
        send_req(7'd1, 5'd7, 1'b1, 64'h7, 64'h7);
        req_valid = 1'b1; req_funct = 7'd2; req_rd = 5'd7; req_xd = 1'b1;
        req_rs1 = 64'h77; req_rs2 = 64'h78;
        #1;
        check("haz_stall", req_ready, 1'b0);
        step(); step(); step();
        check("haz_still_stall", req_ready, 1'b0);
        req_rd = 5'd8;
        #1;
        check("haz_other_rd", req_ready, 1'b1);
        step();
        check("haz_rd8_issued", {io_cmd_valid, io_cmd_bits_inst_rd}, {1'b1, 5'd8});
        req_rd = 5'd7;
        io_resp_valid = 1'b1; io_resp_bits_rd = 5'd7; io_resp_bits_data = 64'h700;
        #1;
        check("haz_same_cycle_clear", req_ready, 1'b0);
        step();
        io_resp_valid = 1'b0;
        #1;
        check("haz_rsp_rd", {rsp_valid, rsp_rd}, {1'b1, 5'd7});
        check("haz_release", req_ready, 1'b1);
        check("haz_not_yet_issued", io_cmd_valid, 1'b0);
        step();
        req_valid = 1'b0;
        check("haz_rd7_issued", {io_cmd_valid, io_cmd_bits_inst_rd, io_cmd_bits_inst_funct},
              {1'b1, 5'd7, 7'd2});
        send_resp(5'd8, 64'h800);
        send_resp(5'd7, 64'h701);
        step(); step();
        check("haz_busy_idle", busy, 1'b0);
        check("haz_no_unexpected", err_unexpected, 1'b0);

        // Outstanding cap and full response FIFO.
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_req(7'd1, 5'(10 + i), 1'b1, 64'(i), 64'h0);
        req_valid = 1'b1; req_funct = 7'd1; req_rd = 5'd18; req_xd = 1'b1;
        #1;
        check("cap_stall", req_ready, 1'b0);
        step(); step();
        check("cap_still_stall", req_ready, 1'b0);
        req_xd = 1'b0;
        #1;
        check("cap_xd0_pass", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) send_resp(5'(10 + i), 64'(16'h100 + i));
        io_resp_valid = 1'b1; io_resp_bits_rd = 5'd14; io_resp_bits_data = 64'h104;
        #1;
        check("fifo_full", io_resp_ready, 1'b0);
        check("fifo_head", {rsp_rd, rsp_data}, {5'd10, 64'h100});
        step();
        check("fifo_full_hold", io_resp_ready, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check("fifo_after_pop", io_resp_ready, 1'b1);
        step();
        io_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fifo_order", {rsp_valid, rsp_rd, rsp_data}, {1'b1, 5'(11 + i), 64'(16'h101 + i)});
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_resp(5'(15 + i), 64'h0);
        step(); step();
        check("cap_busy_idle", busy, 1'b0);
        check("cap_no_unexpected", err_unexpected, 1'b0);

        // Unexpected response is flagged yet still delivered.
        send_resp(5'd3, 64'h33);
        check("unexp_flag", err_unexpected, 1'b1);
        check("unexp_delivered", {rsp_valid, rsp_rd, rsp_data}, {1'b1, 5'd3, 64'h33});
        step();

        // Timeout: one pending command, no response.
        send_req(7'd1, 5'd20, 1'b1, 64'h20, 64'h0);
        repeat (1023) step();
        check("tmo_before", err_timeout, 1'b0);
        step();
        check("tmo_set", err_timeout, 1'b1);

        // Async reset mid-transfer.
        rsp_ready = 1'b0;
        send_req(7'd1, 5'd21, 1'b1, 64'h0, 64'h0);
        send_req(7'd1, 5'd22, 1'b1, 64'h0, 64'h0);
        send_resp(5'd20, 64'h2020);
        io_cmd_ready = 1'b0;
        send_req(7'd2, 5'd23, 1'b0, 64'h5A5A, 64'h0);
        check("pre_rst_state", {busy, rsp_valid, io_cmd_valid}, 3'b111);
        check("pre_rst_errs", {err_bad_funct, err_unexpected, err_timeout}, 3'b111);
        #3 reset = 1'b0;
        #1;
        check("arst_cmd_valid", io_cmd_valid, 1'b0);
        check("arst_cmd_data", {io_cmd_bits_inst_funct, io_cmd_bits_inst_rd, io_cmd_bits_rs1},
              {7'd0, 5'd0, 64'h0});
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_resp_ready", io_resp_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_errs", {err_bad_funct, err_unexpected, err_timeout}, 3'b000);
        #1 reset = 1'b1;
        io_cmd_ready = 1'b1;
        req_valid = 1'b1; req_funct = 7'd1; req_rd = 5'd21; req_xd = 1'b1;
        #1;
        check("arst_scoreboard_clear", req_ready, 1'b1);
        req_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
